matrix_op_sequencer: RTL and testbench

Sequences one matrix instruction of the coprocessor end to end. It loads operand matrices A and B (5x5, 8-bit elements) byte by byte from data memory and starts the matrix ALU. It then writes the result matrix back to memory. It sits between the instruction FSM (EXECUTE stage), the byte-wide data memory and the ALU, and owns the memory port for the duration of an arithmetic instruction.

---
 rtl/matrix_op_sequencer_pkg.sv | 34 +++
 rtl/matrix_op_sequencer_if.sv | 41 ++++
 rtl/mat_xfer_ctrl.sv | 37 +++
 rtl/matrix_op_sequencer.sv | 96 +++++++++
 tb/tb_matrix_op_sequencer.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/matrix_op_sequencer_pkg.sv
// coproc_pkg: shared opcodes, matrix geometry and sequencer state encoding
package coproc_pkg;
   localparam int ELEM_W    = 8;
   localparam int MAT_ELEMS = 25;
   localparam int MAT_W     = ELEM_W * MAT_ELEMS;
   localparam int IDX_W     = 5;

   localparam logic [3:0] OP_READ   = 4'd1;
   localparam logic [3:0] OP_WRITE  = 4'd2;
   localparam logic [3:0] OP_SUM    = 4'd3;
   localparam logic [3:0] OP_SUB    = 4'd4;
   localparam logic [3:0] OP_MUL    = 4'd5;
   localparam logic [3:0] OP_TRANSP = 4'd6;
   localparam logic [3:0] OP_OPST   = 4'd7;
   localparam logic [3:0] OP_MULSCL = 4'd8;
   localparam logic [3:0] OP_DET2   = 4'd9;
   localparam logic [3:0] OP_DET3   = 4'd10;
   localparam logic [3:0] OP_DET4   = 4'd11;
   localparam logic [3:0] OP_DET5   = 4'd12;

   typedef enum logic [2:0] {S_IDLE, S_LOAD_A, S_LOAD_B, S_EXEC, S_STORE, S_FIN} seq_state_t;

   function automatic logic op_valid(input logic [3:0] op);
      return op >= OP_SUM && op <= OP_DET5;
   endfunction

   function automatic logic op_binary(input logic [3:0] op);
      return op == OP_SUM || op == OP_SUB || op == OP_MUL;
   endfunction

   function automatic logic op_det(input logic [3:0] op);
      return op >= OP_DET2 && op <= OP_DET5;
   endfunction
endpackage

// File: rtl/matrix_op_sequencer_if.sv
// matrix_op_sequencer_if: command, data-memory and matrix-ALU signals of the sequencer
interface matrix_op_sequencer_if #(
   parameter int ADDR_W = 9
);
   logic                         cmd_valid;
   logic                         cmd_ready;
   logic [3:0]                   cmd_opcode;
   logic [ADDR_W-1:0]            cmd_addr_a;
   logic [ADDR_W-1:0]            cmd_addr_b;
   logic [ADDR_W-1:0]            cmd_addr_c;
   logic [7:0]                   cmd_scalar;
   logic                         done;
   logic                         err;
   logic                         mem_req;
   logic                         mem_we;
   logic [ADDR_W-1:0]            mem_addr;
   logic [7:0]                   mem_wdata;
   logic [7:0]                   mem_rdata;
   logic                         mem_ack;
   logic                         alu_start;
   logic [3:0]                   alu_op;
   logic [7:0]                   alu_scalar;
   logic [coproc_pkg::MAT_W-1:0] alu_a;
   logic [coproc_pkg::MAT_W-1:0] alu_b;
   logic                         alu_done;
   logic [coproc_pkg::MAT_W-1:0] alu_result;

   modport master (
      input  cmd_valid, cmd_opcode, cmd_addr_a, cmd_addr_b, cmd_addr_c, cmd_scalar,
      input  mem_rdata, mem_ack, alu_done, alu_result,
      output cmd_ready, done, err, mem_req, mem_we, mem_addr, mem_wdata,
      output alu_start, alu_op, alu_scalar, alu_a, alu_b
   );

   modport slave (
      output cmd_valid, cmd_opcode, cmd_addr_a, cmd_addr_b, cmd_addr_c, cmd_scalar,
      output mem_rdata, mem_ack, alu_done, alu_result,
      input  cmd_ready, done, err, mem_req, mem_we, mem_addr, mem_wdata,
      input  alu_start, alu_op, alu_scalar, alu_a, alu_b
   );
endinterface

// File: rtl/mat_xfer_ctrl.sv
// mat_xfer_ctrl: element counter and byte-wide memory request/ack engine for one matrix transfer
module mat_xfer_ctrl
   import coproc_pkg::*;
#(
   parameter int ADDR_W = 9
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              act_i,
   input  logic              we_i,
   input  logic [IDX_W-1:0]  last_i,
   input  logic [ADDR_W-1:0] base_i,
   input  logic              ack_i,
   output logic              req_o,
   output logic              we_o,
   output logic [ADDR_W-1:0] addr_o,
   output logic [IDX_W-1:0]  idx_o,
   output logic              beat_o,
   output logic              done_o
);
   logic [IDX_W-1:0] k_q, k_d;

   assign req_o  = act_i;
   assign we_o   = act_i & we_i;
   assign addr_o = act_i ? base_i + ADDR_W'(k_q) : '0;
   assign idx_o  = k_q;
   assign beat_o = act_i & ack_i;
   assign done_o = beat_o && k_q == last_i;

   // advance on each acked beat; the final beat (or leaving the transfer) clears for the next phase
   always_comb k_d = (!act_i || done_o) ? '0 : k_q + IDX_W'(beat_o);

   // element counter register
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) k_q <= '0;
      else        k_q <= k_d;
endmodule

// File: rtl/matrix_op_sequencer.sv
// matrix_op_sequencer: loads A/B from memory, runs the matrix ALU and stores the result for one instruction
module matrix_op_sequencer
   import coproc_pkg::*;
#(
   parameter int ADDR_W = 9
) (
   input  logic                  clk,
   input  logic                  rst_n,
   matrix_op_sequencer_if.master bus
);
   seq_state_t        state_q, state_d;
   logic [3:0]        op_q;
   logic [ADDR_W-1:0] addr_a_q, addr_b_q, addr_c_q;
   logic [7:0]        scalar_q;
   logic              err_q, started_q;
   logic [MAT_W-1:0]  a_q, b_q, c_q;
   logic              x_act, x_beat, x_done;
   logic [IDX_W-1:0]  x_idx, x_last;
   logic [ADDR_W-1:0] x_base;

   assign x_act  = state_q inside {S_LOAD_A, S_LOAD_B, S_STORE};
   assign x_base = state_q == S_LOAD_A ? addr_a_q : state_q == S_LOAD_B ? addr_b_q : addr_c_q;
   assign x_last = (state_q == S_STORE && op_det(op_q)) ? '0 : IDX_W'(MAT_ELEMS - 1);

   mat_xfer_ctrl #(.ADDR_W(ADDR_W)) u_xfer (
      .clk    (clk),
      .rst_n  (rst_n),
      .act_i  (x_act),
      .we_i   (state_q == S_STORE),
      .last_i (x_last),
      .base_i (x_base),
      .ack_i  (bus.mem_ack),
      .req_o  (bus.mem_req),
      .we_o   (bus.mem_we),
      .addr_o (bus.mem_addr),
      .idx_o  (x_idx),
      .beat_o (x_beat),
      .done_o (x_done)
   );

   assign bus.cmd_ready  = state_q == S_IDLE;
   assign bus.done       = state_q == S_FIN;
   assign bus.err        = state_q == S_FIN && err_q;
   assign bus.alu_start  = state_q == S_EXEC && !started_q;
   assign bus.alu_op     = op_q;
   assign bus.alu_scalar = scalar_q;
   assign bus.alu_a      = a_q;
   assign bus.alu_b      = b_q;
   assign bus.mem_wdata  = state_q == S_STORE ? c_q[ELEM_W*x_idx +: ELEM_W] : '0;

   // next-state: phases advance on the last acked beat or on ALU completion
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (bus.cmd_valid) state_d = op_valid(bus.cmd_opcode) ? S_LOAD_A : S_FIN;
         S_LOAD_A: if (x_done) state_d = op_binary(op_q) ? S_LOAD_B : S_EXEC;
         S_LOAD_B: if (x_done) state_d = S_EXEC;
         S_EXEC:   if (started_q && bus.alu_done) state_d = S_STORE;
         S_STORE:  if (x_done) state_d = S_FIN;
         default:  state_d = S_IDLE;
      endcase
   end

   // state register
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;

   // command latch, operand capture and result capture
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         op_q      <= '0;
         addr_a_q  <= '0;
         addr_b_q  <= '0;
         addr_c_q  <= '0;
         scalar_q  <= '0;
         err_q     <= 1'b0;
         started_q <= 1'b0;
         a_q       <= '0;
         b_q       <= '0;
         c_q       <= '0;
      end else begin
         if (state_q == S_IDLE && bus.cmd_valid) begin
            op_q     <= bus.cmd_opcode;
            addr_a_q <= bus.cmd_addr_a;
            addr_b_q <= bus.cmd_addr_b;
            addr_c_q <= bus.cmd_addr_c;
            scalar_q <= bus.cmd_scalar;
            err_q    <= !op_valid(bus.cmd_opcode);
         end
         started_q <= state_q == S_EXEC;
         if (state_q == S_LOAD_A && x_beat) a_q[ELEM_W*x_idx +: ELEM_W] <= bus.mem_rdata;
         if (state_q == S_LOAD_B && x_beat) b_q[ELEM_W*x_idx +: ELEM_W] <= bus.mem_rdata;
         if (state_q == S_EXEC && started_q && bus.alu_done) c_q <= bus.alu_result;
      end
endmodule

// File: tb/tb_matrix_op_sequencer.sv
// tb_matrix_op_sequencer: directed scenarios against a byte memory model and an adding ALU stub
module tb_matrix_op_sequencer;
   import coproc_pkg::*;

   logic clk, rst_n;
   matrix_op_sequencer_if #(.ADDR_W(9)) bus ();
   matrix_op_sequencer #(.ADDR_W(9)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   logic [7:0] mem [512];
   int checks = 0, errors = 0;
   int cyc = 0, t0 = 0, wait_n = 0, wcnt = 0, acnt = 0;
   int rd_addr[$], rd_cyc[$], wr_addr[$], wr_data[$];
   int n_start = 0, start_rel = -1, n_done = 0, done_rel = -1, done0 = 0;
   logic done_err = 1'b0;

   function automatic logic [MAT_W-1:0] sum_mat(input logic [MAT_W-1:0] a, input logic [MAT_W-1:0] b);
      logic [MAT_W-1:0] r;
      for (int k = 0; k < MAT_ELEMS; k++) r[8*k +: 8] = a[8*k +: 8] + b[8*k +: 8];
      return r;
   endfunction

   assign bus.mem_rdata  = mem[bus.mem_addr];
   assign bus.mem_ack    = bus.mem_req && wcnt == wait_n;
   assign bus.alu_done   = acnt == 1;
   assign bus.alu_result = sum_mat(bus.alu_a, bus.alu_b);

   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk) wcnt <= (bus.mem_req && !bus.mem_ack) ? wcnt + 1 : 0;
   always @(posedge clk)
      if (!rst_n) acnt <= 0;
      else if (bus.alu_start) acnt <= 3;
      else if (acnt > 0) acnt <= acnt - 1;

   always @(negedge clk)
      if (rst_n) begin
         if (bus.mem_req && bus.mem_ack) begin
            if (bus.mem_we) begin
               wr_addr.push_back(int'(bus.mem_addr));
               wr_data.push_back(int'(bus.mem_wdata));
               mem[bus.mem_addr] = bus.mem_wdata;
            end else begin
               rd_addr.push_back(int'(bus.mem_addr));
               rd_cyc.push_back(cyc - t0);
            end
         end
         if (bus.alu_start) begin
            n_start++;
            start_rel = cyc - t0;
         end
         if (bus.done) begin
            n_done++;
            done_rel = cyc - t0;
            done_err = bus.err;
         end
      end

   task automatic run_cmd(input logic [3:0] op, input int a, input int b, input int c, input logic [7:0] s);
      rd_addr.delete(); rd_cyc.delete(); wr_addr.delete(); wr_data.delete();
      start_rel = -1; done_rel = -1; done0 = n_done;
      @(posedge clk); #1;
      bus.cmd_valid = 1'b1; bus.cmd_opcode = op; bus.cmd_scalar = s;
      bus.cmd_addr_a = 9'(a); bus.cmd_addr_b = 9'(b); bus.cmd_addr_c = 9'(c);
      t0 = cyc;
      @(posedge clk); #1;
      bus.cmd_valid = 1'b0;
   endtask

   task automatic wait_done(input string name);
      for (int i = 0; i < 400 && n_done == done0; i++) @(posedge clk);
      #1;
      checks++;
      if (n_done == done0) begin errors++; $display("FAIL %s_timeout no done within 400 cycles", name); end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.cmd_valid = 1'b0; bus.cmd_opcode = '0; bus.cmd_scalar = '0;
      bus.cmd_addr_a = '0; bus.cmd_addr_b = '0; bus.cmd_addr_c = '0;
      repeat (2) @(posedge clk); #1;
      checks++;
      if ({bus.cmd_ready, bus.done, bus.err, bus.mem_req, bus.mem_we, bus.alu_start} !== 6'b100000) begin
         errors++; $display("FAIL reset_ctrl got %b exp 100000", {bus.cmd_ready, bus.done, bus.err, bus.mem_req, bus.mem_we, bus.alu_start});
      end
      checks++;
      if ({bus.mem_addr, bus.mem_wdata, bus.alu_op, bus.alu_scalar, bus.alu_a, bus.alu_b} !== '0) begin
         errors++; $display("FAIL reset_data got nonzero addr %0h wdata %0h op %0h", bus.mem_addr, bus.mem_wdata, bus.alu_op);
      end
      rst_n = 1'b1;
      repeat (5) @(posedge clk); #1;
      checks++;
      if ({bus.cmd_ready, bus.mem_req, bus.alu_start} !== 3'b100) begin
         errors++; $display("FAIL idle_ctrl got %b exp 100", {bus.cmd_ready, bus.mem_req, bus.alu_start});
      end
      checks++;
      if (n_done !== 0) begin errors++; $display("FAIL idle_done got %0d pulses exp 0", n_done); end
   endtask

   task automatic test_sum();
      for (int k = 0; k < 25; k++) begin mem[10+k] = 8'(k); mem[100+k] = 8'(2*k); mem[200+k] = 8'h0; end
      wait_n = 0;
      run_cmd(OP_SUM, 10, 100, 200, 8'h0);
      wait_done("sum");
      checks++;
      if (rd_addr.size() !== 50) begin errors++; $display("FAIL sum_nreads got %0d exp 50", rd_addr.size()); end
      for (int k = 0; k < rd_addr.size() && k < 50; k++) begin
         checks++;
         if (rd_addr[k] !== (k < 25 ? 10 + k : 75 + k)) begin
            errors++; $display("FAIL sum_rd_addr[%0d] got %0d exp %0d", k, rd_addr[k], k < 25 ? 10 + k : 75 + k);
         end
      end
      checks++;
      if (start_rel !== 51) begin errors++; $display("FAIL sum_start got %0d exp 51", start_rel); end
      checks++;
      if (wr_addr.size() !== 25) begin errors++; $display("FAIL sum_nwrites got %0d exp 25", wr_addr.size()); end
      for (int k = 0; k < wr_addr.size() && k < 25; k++) begin
         checks++;
         if (wr_addr[k] !== 200 + k || wr_data[k] !== 3 * k) begin
            errors++; $display("FAIL sum_wr[%0d] got %0d/%0d exp %0d/%0d", k, wr_addr[k], wr_data[k], 200 + k, 3 * k);
         end
      end
      checks++;
      if (done_rel !== 80 || done_err !== 1'b0) begin errors++; $display("FAIL sum_done got cyc %0d err %b exp 80 0", done_rel, done_err); end
   endtask

   task automatic test_det4_wait();
      for (int k = 0; k < 25; k++) mem[300+k] = 8'(8'h31 + k);
      mem[400] = 8'h00; mem[401] = 8'hAA;
      wait_n = 2;
      run_cmd(OP_DET4, 300, 100, 400, 8'h0);
      wait_done("det4");
      checks++;
      if (rd_addr.size() !== 25) begin errors++; $display("FAIL det4_nreads got %0d exp 25", rd_addr.size()); end
      for (int k = 0; k < rd_addr.size() && k < 25; k++) begin
         checks++;
         if (rd_addr[k] !== 300 + k || rd_cyc[k] !== 3 * (k + 1)) begin
            errors++; $display("FAIL det4_rd[%0d] got addr %0d cyc %0d exp %0d %0d", k, rd_addr[k], rd_cyc[k], 300 + k, 3 * (k + 1));
         end
      end
      checks++;
      if (start_rel !== 76) begin errors++; $display("FAIL det4_start got %0d exp 76", start_rel); end
      checks++;
      if (wr_addr.size() !== 1 || mem[400] !== 8'h31 || mem[401] !== 8'hAA) begin
         errors++; $display("FAIL det4_write got n %0d m400 %0h m401 %0h exp 1 31 aa", wr_addr.size(), mem[400], mem[401]);
      end
      checks++;
      if (bus.alu_op !== 4'd11) begin errors++; $display("FAIL det4_alu_op got %0d exp 11", bus.alu_op); end
      checks++;
      if (done_rel !== 83 || done_err !== 1'b0) begin errors++; $display("FAIL det4_done got cyc %0d err %b exp 83 0", done_rel, done_err); end
      wait_n = 0;
   endtask

   task automatic test_reject();
      logic [3:0] ops [2] = '{4'd2, 4'd14};
      for (int i = 0; i < 2; i++) begin
         int s0 = n_start;
         run_cmd(ops[i], 10, 100, 200, 8'h0);
         wait_done("reject");
         checks++;
         if (done_rel !== 1 || done_err !== 1'b1) begin
            errors++; $display("FAIL reject_op%0d_done got cyc %0d err %b exp 1 1", ops[i], done_rel, done_err);
         end
         checks++;
         if (rd_addr.size() + wr_addr.size() !== 0 || n_start !== s0) begin
            errors++; $display("FAIL reject_op%0d_activity got mem %0d starts %0d exp 0 0", ops[i], rd_addr.size() + wr_addr.size(), n_start - s0);
         end
      end
   endtask

   task automatic test_wrap();
      run_cmd(OP_TRANSP, 509, 0, 40, 8'h0);
      wait_done("wrap");
      checks++;
      if (rd_addr.size() !== 25) begin errors++; $display("FAIL wrap_nreads got %0d exp 25", rd_addr.size()); end
      for (int k = 0; k < rd_addr.size() && k < 25; k++) begin
         checks++;
         if (rd_addr[k] !== (509 + k) % 512) begin
            errors++; $display("FAIL wrap_rd[%0d] got %0d exp %0d", k, rd_addr[k], (509 + k) % 512);
         end
      end
      checks++;
      if (done_rel !== 55 || done_err !== 1'b0) begin errors++; $display("FAIL wrap_done got cyc %0d err %b exp 55 0", done_rel, done_err); end
   endtask

   task automatic test_reset_mid();
      int d0;
      run_cmd(OP_SUM, 10, 100, 200, 8'h0);
      repeat (35) @(posedge clk); #1;
      checks++;
      if (bus.mem_req !== 1'b1 || bus.mem_addr !== 9'd110) begin
         errors++; $display("FAIL mid_pre got req %b addr %0d exp 1 110", bus.mem_req, bus.mem_addr);
      end
      d0 = n_done;
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({bus.cmd_ready, bus.done, bus.err, bus.mem_req, bus.mem_we, bus.alu_start} !== 6'b100000) begin
         errors++; $display("FAIL mid_ctrl got %b exp 100000", {bus.cmd_ready, bus.done, bus.err, bus.mem_req, bus.mem_we, bus.alu_start});
      end
      checks++;
      if ({bus.mem_addr, bus.mem_wdata, bus.alu_op, bus.alu_scalar, bus.alu_a, bus.alu_b} !== '0) begin
         errors++; $display("FAIL mid_data got nonzero addr %0h op %0h", bus.mem_addr, bus.alu_op);
      end
      repeat (2) @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (3) @(posedge clk); #1;
      checks++;
      if (n_done !== d0) begin errors++; $display("FAIL mid_no_done got %0d pulses exp 0", n_done - d0); end
      run_cmd(OP_MULSCL, 300, 0, 450, 8'h5A);
      wait_done("mulscl");
      checks++;
      if (bus.alu_scalar !== 8'h5A) begin errors++; $display("FAIL mulscl_scalar got %0h exp 5a", bus.alu_scalar); end
      checks++;
      if (rd_addr.size() !== 25 || wr_addr.size() !== 25) begin
         errors++; $display("FAIL mulscl_counts got %0d/%0d exp 25/25", rd_addr.size(), wr_addr.size());
      end
      for (int k = 0; k < wr_addr.size() && k < 25; k++) begin
         checks++;
         if (wr_addr[k] !== 450 + k || wr_data[k] !== 8'h31 + k) begin
            errors++; $display("FAIL mulscl_wr[%0d] got %0d/%0h exp %0d/%0h", k, wr_addr[k], wr_data[k], 450 + k, 8'h31 + k);
         end
      end
      checks++;
      if (done_rel !== 55 || done_err !== 1'b0) begin errors++; $display("FAIL mulscl_done got cyc %0d err %b exp 55 0", done_rel, done_err); end
   endtask

   initial begin
      for (int i = 0; i < 512; i++) mem[i] = 8'h0;
      test_reset();
      test_sum();
      test_det4_wait();
      test_reject();
      test_wrap();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
